// File: rtl/phit_injector.sv
// Terminal-side injection stage: buffers packet words and bursts each complete packet as head/body/tail phits.
// Optional macro INJ_BACK_TO_BACK_EN removes the idle phit between consecutive packets.
module phit_injector #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [5:0]  i_route,
    input  logic [9:0]  i_payload,
    input  logic        i_last,
    output logic [17:0] o_phit,
    output logic        o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        TAIL1,
        DROP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [17:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   pkt_cnt;
    logic            expect_first;
    logic            gap_pending;
    logic            hold_gap;

    logic            accept;
    logic            wr_en;
    logic            pop;
    logic            flush;
    logic            tail_issue;
    logic [17:0]     phit_next;

    // Entry layout: {first, last, route, payload}
    logic            rd_first;
    logic            rd_last;
    logic [5:0]      rd_route;
    logic [9:0]      rd_payload;

    assign {rd_first, rd_last, rd_route, rd_payload} = mem[rd_ptr];

    assign o_ready = i_rst_n && ((count != FULL) || pop || (state == DROP));
    assign accept  = i_valid && o_ready;
    assign wr_en   = accept && (state != DROP);

`ifdef INJ_BACK_TO_BACK_EN
    assign hold_gap = 1'b0;
`else
    assign hold_gap = tail_issue;
`endif

    always_comb begin
        state_next = state;
        phit_next  = 18'h0;
        pop        = 1'b0;
        flush      = 1'b0;
        tail_issue = 1'b0;
        case (state)
            IDLE: begin
                // A full FIFO with no complete packet can never drain: drop it.
                if (count == FULL && pkt_cnt == '0) begin
                    flush      = 1'b1;
                    state_next = DROP;
                end else if (pkt_cnt != '0 && !gap_pending) begin
                    pop        = 1'b1;
                    phit_next  = {2'b01, (rd_first ? rd_route : 6'd0), rd_payload};
                    state_next = rd_last ? TAIL1 : SEND;
                end
            end
            SEND: begin
                pop = 1'b1;
                if (rd_last) begin
                    phit_next  = {2'b11, 6'd0, rd_payload};
                    tail_issue = 1'b1;
                    state_next = IDLE;
                end else begin
                    phit_next  = {2'b10, 6'd0, rd_payload};
                end
            end
            TAIL1: begin
                phit_next  = {2'b11, 16'h0};
                tail_issue = 1'b1;
                state_next = IDLE;
            end
            DROP: begin
                if (i_valid && i_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pkt_cnt      <= '0;
            expect_first <= 1'b1;
            gap_pending  <= 1'b0;
            o_phit       <= 18'h0;
            o_err        <= 1'b0;
        end else begin
            state       <= state_next;
            o_phit      <= phit_next;
            gap_pending <= hold_gap;
            if (accept) begin
                expect_first <= i_last;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                o_err  <= 1'b1;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(wr_en) - CW'(pop);
            end
            if (wr_en && i_last && !tail_issue) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end else if (tail_issue && !(wr_en && i_last)) begin
                pkt_cnt <= pkt_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {expect_first, i_last, i_route, i_payload};
        end
    end

endmodule

// File: tb/tb_phit_injector.sv
// Self-checking bench for phit_injector: directed scenarios plus random packets checked against a timing model.
module tb_phit_injector;

    localparam int DEPTH = 4;
`ifdef INJ_BACK_TO_BACK_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [5:0]  i_route = '0;
    logic [9:0]  i_payload = '0;
    logic        i_last = 1'b0;
    logic [17:0] o_phit;
    logic        o_err;

    int checks = 0;
    int passes = 0;

    phit_injector #(.DEPTH(DEPTH)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_route   (i_route),
        .i_payload (i_payload),
        .i_last    (i_last),
        .o_phit    (o_phit),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        acc;
        logic [5:0]  route;
        logic [9:0]  payload;
        logic        last;
        logic [17:0] phit;
        logic        err;
    } entry_t;

    entry_t      log_q[$];
    logic        logging = 1'b0;
    logic        pend_acc = 1'b0;
    logic [5:0]  pend_route = '0;
    logic [9:0]  pend_payload = '0;
    logic        pend_last = 1'b0;

    // One log entry per rising edge: the word accepted at that edge and the phit it produced.
    always @(negedge i_clk) begin
        #1;
        pend_acc     = i_valid && o_ready;
        pend_route   = i_route;
        pend_payload = i_payload;
        pend_last    = i_last;
    end

    always @(posedge i_clk) begin
        entry_t e;
        e.acc     = pend_acc;
        e.route   = pend_route;
        e.payload = pend_payload;
        e.last    = pend_last;
        #2;
        e.phit = o_phit;
        e.err  = o_err;
        if (logging) log_q.push_back(e);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [17:0] observed, input logic [17:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [5:0] r, input logic [9:0] p, input logic l);
        bit done = 1'b0;
        int waited = 0;
        i_valid   = 1'b1;
        i_route   = r;
        i_payload = p;
        i_last    = l;
        while (!done && waited < 20) begin
            #1;
            done = o_ready;
            @(negedge i_clk);
            waited++;
        end
        checkOutput("accept_wait", 18'(done), 18'h1);
    endtask

    task automatic idleInputs();
        i_valid   = 1'b0;
        i_last    = 1'b0;
        i_route   = '0;
        i_payload = '0;
    endtask

    // Expected phit per edge: a packet completed at edge c starts at max(c+1, free),
    // runs max(N,2) consecutive phits, and the next head may not start before tail+GAP+1.
    task automatic checkStream(input string tag);
        logic [17:0] exp_phit[];
        logic [9:0]  pay[$];
        logic [5:0]  route = '0;
        int          free_edge = 0;
        exp_phit = new[log_q.size()];
        foreach (exp_phit[k]) exp_phit[k] = 18'h0;
        for (int k = 0; k < log_q.size(); k++) begin
            if (log_q[k].acc) begin
                if (pay.size() == 0) route = log_q[k].route;
                pay.push_back(log_q[k].payload);
                if (log_q[k].last) begin
                    int h;
                    int len;
                    h   = (k + 1 > free_edge) ? k + 1 : free_edge;
                    len = (pay.size() < 2) ? 2 : pay.size();
                    for (int j = 0; j < len; j++) begin
                        logic [17:0] ph;
                        if (j == 0)            ph = {2'b01, route, pay[0]};
                        else if (j == len - 1) ph = {2'b11, 6'd0, (pay.size() == 1) ? 10'h0 : pay[j]};
                        else                   ph = {2'b10, 6'd0, pay[j]};
                        if (h + j < log_q.size()) exp_phit[h + j] = ph;
                    end
                    free_edge = h + len + GAP;
                    pay.delete();
                end
            end
        end
        for (int k = 0; k < log_q.size(); k++) begin
            checkOutput({tag, "_phit"}, log_q[k].phit, exp_phit[k]);
        end
    endtask

    task automatic checkGap();
        int tail_idx = -1;
        int head_idx = -1;
        for (int k = 0; k < log_q.size(); k++) begin
            if (tail_idx < 0 && log_q[k].phit[17:16] == 2'b11) tail_idx = k;
            else if (tail_idx >= 0 && head_idx < 0 && log_q[k].phit[17:16] == 2'b01) head_idx = k;
        end
        checkOutput("gap_idle_count", 18'(head_idx - tail_idx - 1), 18'(GAP));
    endtask

    task automatic checkOversize();
        int acc_seen = 0;
        int fourth = -1;
        int last_acc = -1;
        int first_ph = -1;
        logic [17:0] ph_q[$];
        for (int k = 0; k < log_q.size(); k++) begin
            if (log_q[k].acc) begin
                acc_seen++;
                last_acc = k;
                if (acc_seen == 4) fourth = k;
            end
            if (log_q[k].phit != 18'h0) begin
                if (first_ph < 0) first_ph = k;
                ph_q.push_back(log_q[k].phit);
            end
        end
        checkOutput("ovr_accepted", 18'(acc_seen), 18'd8);
        checkOutput("ovr_err_before", 18'(log_q[fourth].err), 18'h0);
        checkOutput("ovr_err_rise", 18'(log_q[fourth + 1].err), 18'h1);
        checkOutput("ovr_phit_count", 18'(ph_q.size()), 18'd2);
        checkOutput("ovr_head", ph_q[0], {2'b01, 6'b001010, 10'h2AA});
        checkOutput("ovr_tail", ph_q[1], {2'b11, 6'd0, 10'h155});
        checkOutput("ovr_latency", 18'(first_ph), 18'(last_acc + 1));
        checkOutput("ovr_err_sticky", 18'(log_q[log_q.size() - 1].err), 18'h1);
    endtask

    initial begin
        // Reset and quiet period.
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_phit", o_phit, 18'h0);
        checkOutput("rst_ready", 18'(o_ready), 18'h0);
        checkOutput("rst_err", 18'(o_err), 18'h0);
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            checkOutput("idle_phit", o_phit, 18'h0);
            checkOutput("idle_ready", 18'(o_ready), 18'h1);
        end

        // Three-word packet; later words carry a different route that must be ignored.
        applyStimulus(6'b100111, 10'h001, 1'b0);
        applyStimulus(6'b111111, 10'h002, 1'b0);
        applyStimulus(6'b111111, 10'h003, 1'b1);
        idleInputs();
        checkOutput("p3_latency_idle", o_phit, 18'h0);
        @(negedge i_clk);
        checkOutput("p3_head", o_phit, {2'b01, 6'b100111, 10'h001});
        @(negedge i_clk);
        checkOutput("p3_body", o_phit, {2'b10, 6'd0, 10'h002});
        @(negedge i_clk);
        checkOutput("p3_tail", o_phit, {2'b11, 6'd0, 10'h003});
        @(negedge i_clk);
        checkOutput("p3_after", o_phit, 18'h0);
        repeat (3) @(negedge i_clk);

        // Single-word packet.
        applyStimulus(6'b000001, 10'h3FF, 1'b1);
        idleInputs();
        checkOutput("p1_latency_idle", o_phit, 18'h0);
        @(negedge i_clk);
        checkOutput("p1_head", o_phit, {2'b01, 6'b000001, 10'h3FF});
        @(negedge i_clk);
        checkOutput("p1_tail", o_phit, {2'b11, 6'd0, 10'h000});
        @(negedge i_clk);
        checkOutput("p1_after", o_phit, 18'h0);
        repeat (3) @(negedge i_clk);

        // Two 2-word packets streamed with valid held high.
        log_q.delete();
        logging = 1'b1;
        applyStimulus(6'b011011, 10'h0AA, 1'b0);
        applyStimulus(6'b011011, 10'h0AB, 1'b1);
        applyStimulus(6'b110001, 10'h155, 1'b0);
        applyStimulus(6'b110001, 10'h156, 1'b1);
        idleInputs();
        repeat (10) @(negedge i_clk);
        logging = 1'b0;
        checkStream("stream");
        checkGap();
        repeat (3) @(negedge i_clk);

        // Oversize packet: six words, only the sixth marked last, then a good packet.
        log_q.delete();
        logging = 1'b1;
        for (int i = 1; i <= 6; i++) applyStimulus(6'b010101, 10'(i), i == 6);
        applyStimulus(6'b001010, 10'h2AA, 1'b0);
        applyStimulus(6'b001010, 10'h155, 1'b1);
        idleInputs();
        repeat (8) @(negedge i_clk);
        logging = 1'b0;
        checkOversize();
        repeat (2) @(negedge i_clk);

        // Reset while a four-word packet is mid-body.
        applyStimulus(6'b110110, 10'h011, 1'b0);
        applyStimulus(6'b110110, 10'h012, 1'b0);
        applyStimulus(6'b110110, 10'h013, 1'b0);
        applyStimulus(6'b110110, 10'h014, 1'b1);
        idleInputs();
        @(negedge i_clk);
        checkOutput("rmid_head", o_phit, {2'b01, 6'b110110, 10'h011});
        @(negedge i_clk);
        checkOutput("rmid_body", o_phit, {2'b10, 6'd0, 10'h012});
        i_rst_n = 1'b0;
        @(negedge i_clk);
        checkOutput("rmid_phit", o_phit, 18'h0);
        checkOutput("rmid_ready", 18'(o_ready), 18'h0);
        checkOutput("rmid_err", 18'(o_err), 18'h0);
        i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            checkOutput("rmid_no_tail", o_phit, 18'h0);
        end

        // Random packets with random inter-word bubbles.
        log_q.delete();
        logging = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int n;
            logic [5:0] r;
            n = $urandom_range(1, DEPTH);
            r = 6'($urandom);
            for (int w = 0; w < n; w++) begin
                applyStimulus((w == 0) ? r : 6'($urandom), 10'($urandom), w == n - 1);
                if ($urandom_range(0, 3) == 0) begin
                    idleInputs();
                    @(negedge i_clk);
                end
            end
        end
        idleInputs();
        repeat (40) @(negedge i_clk);
        logging = 1'b0;
        checkStream("rand");
        checkOutput("rand_err", 18'(o_err), 18'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
